// File: rtl/huffman_seq_ctrl.sv
// huffman_seq_ctrl
// Runs one message through the huffman encode/decode core. It buffers the
// upstream symbols while streaming them to the core, waits for the encoder,
// then checks the decoded symbols against the buffer. Each message ends with
// one pass/fail report.
//
// Message flow:
//   IDLE   -> wait for start_i; reject illegal lengths without leaving IDLE
//   LOAD   -> accept len symbols; each accepted symbol is passed to the core
//             in the same cycle
//   ENCODE -> wait for hf_done_en_i; capture the encoded bit count
//   DECODE -> compare each decoded symbol against the buffer
//   REPORT -> pulse done_o for one cycle with the final verdict
//
// ENCODE and DECODE each have a watchdog. It aborts to REPORT once TIMEOUT
// idle cycles have elapsed with no progress.

module huffman_seq_ctrl #(
    parameter int BIT_WIDTH = 8,
    parameter int MAX_LEN   = 255,
    parameter int TIMEOUT   = 4095
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    // message control
    input  logic                 start_i,
    input  logic [7:0]           len_i,

    // upstream symbol stream
    input  logic                 sym_valid_i,
    input  logic [BIT_WIDTH-1:0] sym_i,
    output logic                 sym_ready_o,

    // huffman core interface
    output logic                 hf_data_en_o,
    output logic [BIT_WIDTH-1:0] hf_text_o,
    input  logic                 hf_done_en_i,
    input  logic                 hf_done_de_i,
    input  logic [7:0]           hf_char_i,
    input  logic [10:0]          hf_total_bit_i,

    // status and result
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 err_len_o,
    output logic                 err_timeout_o,
    output logic [10:0]          total_bit_o,
    output logic [7:0]           mismatch_cnt_o
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    // idx and len_q must be able to hold values up to MAX_LEN.
    localparam int IDX_W = $clog2(MAX_LEN + 1);
    // The watchdog must be able to reach TIMEOUT itself.
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENCODE,
        ST_DECODE,
        ST_REPORT
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state;
    logic [IDX_W-1:0]     len_q;      // latched message length
    logic [IDX_W-1:0]     idx;        // buffer position for load and compare
    logic [TMR_W-1:0]     timer;      // watchdog for ENCODE and DECODE

    // Message buffer, written during LOAD and read during DECODE.
    logic [BIT_WIDTH-1:0] sym_buf [MAX_LEN];

    // ------------------------------------------------------------------
    // Derived combinational terms
    // ------------------------------------------------------------------
    logic                 accept;     // upstream handshake completes this cycle
    logic                 len_ok;     // len_i is inside 1..MAX_LEN
    logic                 last_idx;   // idx points at the final symbol
    logic                 timer_exp;  // watchdog has reached its limit
    logic [BIT_WIDTH-1:0] buf_rd;     // buffered symbol at idx
    logic [BIT_WIDTH-1:0] dec_sym;    // decoded symbol, resized to BIT_WIDTH
    logic                 sym_match;  // decoded symbol equals buffered symbol
    logic [7:0]           mm_next;    // mismatch count including this symbol

    // sym_ready_o and the core's data_en follow the state and the upstream
    // valid directly. The core therefore sees each symbol in the same cycle
    // it is accepted.
    assign sym_ready_o  = (state == ST_LOAD);
    assign accept       = sym_ready_o && sym_valid_i;
    assign hf_data_en_o = accept;
    assign hf_text_o    = accept ? sym_i : '0;
    assign busy_o       = (state != ST_IDLE);

    assign len_ok    = (len_i != 8'd0) && (int'(len_i) <= MAX_LEN);
    assign last_idx  = (idx == len_q - IDX_W'(1));
    assign timer_exp = (timer == TMR_W'(TIMEOUT));

    // The buffer read is a plain mux on idx. The decoded symbol is compared
    // in the same cycle it arrives.
    assign buf_rd    = sym_buf[idx];
    assign dec_sym   = BIT_WIDTH'(hf_char_i);
    assign sym_match = (buf_rd == dec_sym);

    // The count saturates so a long, badly corrupted message cannot wrap
    // back to zero and report a pass.
    assign mm_next = (!sym_match && (mismatch_cnt_o != 8'hFF))
                     ? mismatch_cnt_o + 8'd1
                     : mismatch_cnt_o;

    // Buffer write port: store each accepted upstream symbol at idx.
    // NOTE: storage arrays get no reset. Contents are don't-care until
    // written, and a reset term here would block RAM inference.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            sym_buf[idx] <= sym_i;
        end
    end

    // Sequencer FSM. It owns the counters and all registered result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            idx            <= '0;
            timer          <= '0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            err_len_o      <= 1'b0;
            err_timeout_o  <= 1'b0;
            total_bit_o    <= '0;
            mismatch_cnt_o <= '0;
        end else begin
            // NOTE: done_o gets a default low at the top of the clocked
            // branch, so it is a one-cycle pulse. Only the transitions that
            // report a result raise it.
            done_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        // A new start clears the previous message's results,
                        // whether or not its length is legal.
                        pass_o         <= 1'b0;
                        err_timeout_o  <= 1'b0;
                        total_bit_o    <= '0;
                        mismatch_cnt_o <= '0;
                        if (len_ok) begin
                            len_q     <= IDX_W'(len_i);
                            idx       <= '0;
                            timer     <= '0;
                            err_len_o <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            // Illegal length: report at once and stay idle.
                            err_len_o <= 1'b1;
                            done_o    <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        if (last_idx) begin
                            idx   <= '0;
                            timer <= '0;
                            state <= ST_ENCODE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                ST_ENCODE: begin
                    // A done_de in the same cycle as done_en is dropped.
                    // Collection starts in DECODE.
                    if (hf_done_en_i) begin
                        total_bit_o <= hf_total_bit_i;
                        timer       <= '0;
                        state       <= ST_DECODE;
                    end else if (timer_exp) begin
                        err_timeout_o <= 1'b1;
                        pass_o        <= 1'b0;
                        done_o        <= 1'b1;
                        state         <= ST_REPORT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                ST_DECODE: begin
                    if (hf_done_de_i) begin
                        // Each decoded symbol restarts the watchdog.
                        mismatch_cnt_o <= mm_next;
                        timer          <= '0;
                        if (last_idx) begin
                            idx    <= '0;
                            pass_o <= (mm_next == 8'd0);
                            done_o <= 1'b1;
                            state  <= ST_REPORT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (timer_exp) begin
                        err_timeout_o <= 1'b1;
                        pass_o        <= 1'b0;
                        done_o        <= 1'b1;
                        state         <= ST_REPORT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                ST_REPORT: begin
                    // done_o is high for this one cycle. Any surplus decoded
                    // symbols arriving now are ignored.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/huffman_seq_ctrl.md
Name: huffman_seq_ctrl

Overview:
- Sequences one message through the huffman encode/decode core.
- Accepts a byte stream from an upstream requester (valid/ready) and buffers it.
- Drives the core's data_en/input_text interface, waits for encode completion and captures the total encoded bit count.
- Collects the decoded symbols, compares them against the buffer, and reports a single pass/fail result per message.

Parameters:
BIT_WIDTH, 8, symbol width; must match the core.
MAX_LEN, 255, maximum symbols per message; sizes the buffer and counters.
TIMEOUT, 4095, maximum cycles allowed in ENCODE, and again in DECODE, before abort.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin message; sampled only in IDLE
len_i  in  8  message length in symbols; valid range 1..MAX_LEN; sampled with start_i
sym_valid_i  in  1  upstream symbol valid
sym_i  in  BIT_WIDTH  upstream symbol
sym_ready_o  out  1  controller accepts a symbol
hf_data_en_o  out  1  to core data_en_i
hf_text_o  out  BIT_WIDTH  to core input_text_i
hf_done_en_i  in  1  from core done_en_o
hf_done_de_i  in  1  from core done_de_o; each high cycle carries one decoded symbol
hf_char_i  in  8  from core char_o
hf_total_bit_i  in  11  from core total_bit_o
busy_o  out  1  high when not in IDLE
done_o  out  1  one-cycle pulse; result outputs are valid in that cycle
pass_o  out  1  last message decoded identically with no errors
err_len_o  out  1  last start_i carried an illegal len_i
err_timeout_o  out  1  last message aborted by timeout
total_bit_o  out  11  encoded bit count captured from the core
mismatch_cnt_o  out  8  count of decoded symbols differing from input; saturates at 255

Behaviour:
- Reset: FSM to IDLE; all outputs 0; buffer contents don't-care.
- Reset mid-message aborts immediately; no done_o is produced.
- States: IDLE, LOAD, ENCODE, DECODE, REPORT.
- IDLE, start_i=1 with len_i=0 or len_i>MAX_LEN:
  - err_len_o=1, pass_o=0, done_o pulses next cycle.
  - Stays in IDLE; other result outputs cleared.
- IDLE, start_i=1 with legal len_i:
  - Latch len; clear idx, mismatch count, timer and error flags; go to LOAD.
- LOAD:
  - sym_ready_o=1.
  - On each sym_valid_i&&sym_ready_o: write buf[idx]=sym_i; hf_data_en_o=1 and hf_text_o=sym_i in the same cycle (combinational pass-through); idx++.
  - Cycles with sym_valid_i=0 keep hf_data_en_o=0. Gaps are legal.
  - After the len-th accepted symbol: clear idx and timer; go to ENCODE.
  - sym_ready_o is 0 in every state other than LOAD.
- ENCODE:
  - Timer increments each cycle.
  - hf_done_en_i=1: capture hf_total_bit_i into total_bit_o; clear timer; go to DECODE.
  - Timer reaching TIMEOUT: err_timeout_o=1; go to REPORT.
- DECODE:
  - Each cycle with hf_done_de_i=1: compare hf_char_i against buf[idx]; on mismatch, increment mismatch count (saturating); idx++.
  - After len decoded symbols: go to REPORT.
  - Timer counts only cycles with no hf_done_de_i; it resets on each symbol. Reaching TIMEOUT sets err_timeout_o and goes to REPORT.
  - hf_done_en_i and hf_done_de_i high in the same cycle on the ENCODE exit: that done_de cycle is ignored; decode collection starts the next cycle.
  - Surplus hf_done_de_i after len symbols is ignored.
- REPORT:
  - One cycle: done_o=1.
  - pass_o = (mismatch==0) && !err_timeout_o.
  - Go to IDLE.
- Result outputs hold until the next start_i is accepted.
- start_i outside IDLE is ignored.
- Buffer read for the comparison is combinational on idx; no extra pipeline stage.
- Latency, start_i accepted to done_o, with no upstream gaps: 1 + len (LOAD) + encode wait + decode wait + 1.

Test Plan:
1. start_i, len_i=4, symbols "ABAB" with no gaps; core echoes done_en with total_bit=4, then decodes "ABAB" -> hf_data_en_o high for exactly 4 cycles, total_bit_o=4, mismatch_cnt_o=0, pass_o=1, one done_o pulse.
2. Same message with 3-cycle gaps between upstream symbols -> hf_data_en_o asserted only on accept cycles; identical results to scenario 1.
3. len_i=3 "XYZ"; core decodes "XQZ" -> mismatch_cnt_o=1, pass_o=0.
4. len_i=2; core never asserts done_en -> done_o exactly TIMEOUT+1 cycles after ENCODE entry; err_timeout_o=1, pass_o=0.
5. start_i with len_i=0 -> err_len_o=1, done_o next cycle, busy_o stays 0, sym_ready_o never asserted.
6. rst_ni low during DECODE -> all outputs 0 at once, no done_o; a following len_i=1 message completes with pass_o=1.
